ifu: RTL and testbench
======================

Name: ifu

Overview:
- Instruction fetch unit directly upstream of the instruction decoder in the P4-style MIPS core.
- Holds the PC and fetches words from an external instruction memory over a request/response handshake.
- Presents the fetched instruction to the decoder with a valid flag.
- When the datapath commits, computes the next PC from the decoder's next-PC select, the branch outcome, the jump fields and the jr register value.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles spent in WAIT before an error (used only with IFU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  one-cycle fetch request.
- imem_addr  out  32  byte address of the fetch; equals pc.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction word.
- instr  out  32  current instruction, to the decoder.
- instr_valid  out  1  instr is stable and executable.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4, used for the jal link value.
- commit  in  1  datapath has finished the current instruction.
- next_pc_op  in  3  next-PC select: 0 sequential, 1 beq, 2 jal, 3 jr, 4-7 treated as 0.
- branch_taken  in  1  beq compare result (equal).
- imm16  in  16  branch offset field.
- j_address  in  26  jump target field.
- rs_data  in  32  jr target register value.
- fetch_err  out  1  sticky error flag; the unit is halted while it is set.

Behaviour:
- Reset values (while reset=0, asynchronous):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0.
  - state=IDLE, timeout counter=0.
- IDLE: move to REQ on the next edge.
- REQ:
  - imem_req=1 and imem_addr=pc for exactly one cycle.
  - Move to WAIT.
- WAIT:
  - On imem_rvalid=1: instr<=imem_rdata, instr_valid<=1, move to HOLD.
  - The earliest legal response is the cycle after REQ; zero-wait memory is therefore 1 cycle of latency.
- HOLD:
  - instr_valid=1; instr and pc are held stable.
  - On commit=1: pc<=next_pc, instr_valid<=0, move to REQ.
  - Result: commit in cycle N gives imem_req with the new address in cycle N+1.
- HALT:
  - Terminal state; imem_req=0, instr_valid=0, fetch_err=1.
  - Only reset exits HALT.
- Ignored inputs:
  - imem_rvalid outside WAIT is ignored.
  - commit outside HOLD is ignored.
- next_pc (all arithmetic is 32-bit, wraps modulo 2^32):
  - op 0 or 4-7: pc+4.
  - op 1: branch_taken ? pc+4+(sign_ext(imm16)<<2) : pc+4.
  - op 2: {pc[31:28], j_address, 2'b00}.
  - op 3: rs_data.
- Misaligned target: if next_pc[1:0]!=0 at commit, set fetch_err=1, leave pc unchanged, enter HALT. In practice this only occurs for jr.
- pc_plus4 is combinational pc+4; at pc=32'hFFFF_FFFC it wraps to 0.
- Reset mid-operation:
  - Any in-flight fetch is abandoned.
  - The instruction memory shares the same reset, so no stale response arrives after reset.
- imem_addr is driven from the pc register and is not affected by the current-cycle inputs.

Optional Feature:
- Macro: IFU_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle without imem_rvalid.
  - When the counter reaches TIMEOUT: fetch_err<=1, go to HALT.
  - A response in the same cycle the count reaches TIMEOUT wins: the instruction is accepted and there is no error.
- Undefined: no counter is built; WAIT lasts indefinitely; fetch_err comes only from misalignment.

Decomposition:
- Package ifu_pkg:
  - next_pc_op encodings NPC_SEQ=3'd0, NPC_BEQ=3'd1, NPC_JAL=3'd2, NPC_JR=3'd3; these must match the decoder's encodings.
  - State encoding: IDLE, REQ, WAIT, HOLD, HALT.
  - Default RESET_PC constant.
- Sub-module npc: purely combinational next-PC calculator.
  - Inputs: pc, next_pc_op, branch_taken, imm16, j_address, rs_data.
  - Outputs: next_pc, misaligned.
  - The FSM and registers stay in ifu.

Test Plan:
- Reset release, memory returns 32'h3C01_1234 one cycle after the request → imem_req at cycle 1 with addr 0x3000; instr_valid=1 at cycle 3; pc=0x3000.
- commit with op 0, four times → fetch addresses 0x3004, 0x3008, 0x300C, 0x3010; each imem_req is exactly one cycle.
- pc=0x3010, op 1, imm16=16'hFFFC, branch_taken=1 → next pc 0x3004; with branch_taken=0 → 0x3014.
- pc=0x3020, op 2, j_address=26'h0000C10 → next pc 0x0000_3040; then op 3 with rs_data=0x3024 → next pc 0x3024.
- op 3, rs_data=0x3025 → fetch_err=1, HALT, pc stays; further commits are ignored; reset clears the error.
- With IFU_TIMEOUT_EN and TIMEOUT=4, no imem_rvalid → fetch_err after 4 WAIT cycles; rvalid exactly on the 4th cycle → accepted, no error.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared encodings for the instruction fetch unit: next-PC selects, FSM states
// and the default reset PC.
package ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

    // Must stay in step with the decoder's next-PC select encodings.
    localparam logic [2:0] NPC_SEQ = 3'd0;
    localparam logic [2:0] NPC_BEQ = 3'd1;
    localparam logic [2:0] NPC_JAL = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } ifu_state_e;

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC calculator: sequential, beq, jal and jr targets, plus
// a word-alignment check on the selected target.
module ifu_npc
    import ifu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [2:0]  next_pc_op_i,
    input  logic        branch_taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] j_address_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic [31:0] seq_pc;
    logic [31:0] branch_off;

    assign seq_pc     = pc_i + 32'd4;
    assign branch_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};

    always_comb begin
        next_pc_o = seq_pc;
        case (next_pc_op_i)
            NPC_BEQ: next_pc_o = branch_taken_i ? (seq_pc + branch_off) : seq_pc;
            NPC_JAL: next_pc_o = {pc_i[31:28], j_address_i, 2'b00};
            NPC_JR:  next_pc_o = rs_data_i;
            default: next_pc_o = seq_pc;
        endcase
    end

    assign misaligned_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, request/response fetch FSM and commit-time
// PC update. Define IFU_TIMEOUT_EN to bound the response wait to TIMEOUT cycles.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic [2:0]  next_pc_op,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] j_address,
    input  logic [31:0] rs_data,
    output logic        fetch_err
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc;
    logic        npc_misaligned;

`ifdef IFU_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    ifu_npc u_npc (
        .pc_i           (pc_q),
        .next_pc_op_i   (next_pc_op),
        .branch_taken_i (branch_taken),
        .imm16_i        (imm16),
        .j_address_i    (j_address),
        .rs_data_i      (rs_data),
        .next_pc_o      (npc),
        .misaligned_o   (npc_misaligned)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef IFU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                state_d = ST_WAIT;
`ifdef IFU_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                // A response always beats a timeout landing in the same cycle.
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                end
`ifdef IFU_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (commit) begin
                    if (npc_misaligned) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = npc;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode purely from registered state, never from current-cycle inputs.
    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_HOLD);
    assign fetch_err   = (state_q == ST_HALT);
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed fetch/commit sequence plus randomized
// commits scored against a behavioural next-PC model.
module tb_ifu;
    import ifu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic [2:0]  next_pc_op;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] j_address;
    logic [31:0] rs_data;
    logic        fetch_err;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    ifu #(.RESET_PC(32'h0000_3000), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .commit       (commit),
        .next_pc_op   (next_pc_op),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .j_address    (j_address),
        .rs_data      (rs_data),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rules expressed as plain integer arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [2:0] op,
                                             input logic bt, input logic [15:0] imm,
                                             input logic [25:0] ja, input logic [31:0] rs);
        int signed off;
        off = $signed(imm);
        case (op)
            3'd1:    return bt ? cur + 32'd4 + 32'(off * 4) : cur + 32'd4;
            3'd2:    return (cur & 32'hF000_0000) + 32'(ja) * 32'd4;
            3'd3:    return rs;
            default: return cur + 32'd4;
        endcase
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    pc,          32'h0000_3000);
        check({tag, "_instr"}, instr,       32'h0);
        check({tag, "_valid"}, instr_valid, 1'b0);
        check({tag, "_req"},   imem_req,    1'b0);
        check({tag, "_err"},   fetch_err,   1'b0);
    endtask

    // Entered on the REQ cycle; leaves the unit in HOLD with the word accepted.
    task automatic do_fetch(input logic [31:0] data, input int lat);
        check("req_high", imem_req, 1'b1);
        check("req_addr", imem_addr, m_pc);
        step();
        check("req_one_cycle", imem_req, 1'b0);
        for (int i = 0; i < lat; i++) begin
            check("wait_not_valid", instr_valid, 1'b0);
            commit     = 1'($urandom % 2);
            next_pc_op = NPC_JR;
            rs_data    = 32'h0000_0001;
            step();
        end
        commit      = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        m_instr     = data;
        step();
        imem_rvalid = 1'b0;
        check("hold_valid", instr_valid, 1'b1);
        check("hold_instr", instr, m_instr);
        check("hold_pc", pc, m_pc);
        check("hold_pc_plus4", pc_plus4, m_pc + 32'd4);
        imem_rvalid = 1'b1;
        imem_rdata  = ~data;
        step();
        imem_rvalid = 1'b0;
        check("hold_ignores_rvalid", instr, m_instr);
        check("hold_still_valid", instr_valid, 1'b1);
    endtask

    // Entered in HOLD; leaves the unit on the following REQ cycle or in HALT.
    task automatic do_commit(input logic [2:0] op, input logic bt, input logic [15:0] imm,
                             input logic [25:0] ja, input logic [31:0] rs);
        logic [31:0] exp;
        exp          = ref_next(m_pc, op, bt, imm, ja, rs);
        commit       = 1'b1;
        next_pc_op   = op;
        branch_taken = bt;
        imm16        = imm;
        j_address    = ja;
        rs_data      = rs;
        step();
        commit = 1'b0;
        if ((exp % 4) != 0) begin
            check("misalign_err", fetch_err, 1'b1);
            check("misalign_pc_kept", pc, m_pc);
            check("misalign_no_req", imem_req, 1'b0);
            check("misalign_not_valid", instr_valid, 1'b0);
        end else begin
            m_pc = exp;
        end
    endtask

    initial begin
        reset        = 1'b1;
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;
        commit       = 1'b0;
        next_pc_op   = '0;
        branch_taken = 1'b0;
        imm16        = '0;
        j_address    = '0;
        rs_data      = '0;
        m_pc         = 32'h0000_3000;
        m_instr      = '0;
        #1 reset = 1'b0;
        #1 check_reset_state("async_reset");
        step();
        step();
        check_reset_state("held_reset");

        reset = 1'b1;
        check("cycle0_no_req", imem_req, 1'b0);
        step();
        do_fetch(32'h3C01_1234, 0);

        for (int i = 0; i < 4; i++) begin
            do_commit(3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
            do_fetch($urandom, i % 3);
        end
        check("seq_reached", pc, 32'h0000_3010);

        do_commit(3'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0);
        check("beq_taken_pc", m_pc, 32'h0000_3004);
        do_fetch($urandom, 0);
        do_commit(3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3010);
        do_fetch($urandom, 1);
        do_commit(3'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        check("beq_not_taken_addr", imem_addr, 32'h0000_3014);
        do_fetch($urandom, 0);
        do_commit(3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3020);
        do_fetch($urandom, 0);
        do_commit(3'd2, 1'b0, 16'h0, 26'h000_0C10, 32'h0);
        check("jal_addr", imem_addr, 32'h0000_3040);
        do_fetch($urandom, 2);
        do_commit(3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3024);
        check("jr_addr", imem_addr, 32'h0000_3024);
        do_fetch($urandom, 0);

        for (int i = 0; i < 40; i++) begin
            do_commit(3'($urandom), 1'($urandom), 16'($urandom), 26'($urandom),
                      $urandom & 32'hFFFF_FFFC);
            do_fetch($urandom, int'($urandom % 4));
        end

        do_commit(3'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        do_fetch($urandom, 0);
        check("pc_plus4_wrap", pc_plus4, 32'h0);
        do_commit(3'd5, 1'b0, 16'h0, 26'h0, 32'h0);
        check("wrap_fetch_addr", imem_addr, 32'h0);
        do_fetch($urandom, 0);
        do_commit(3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3024);
        do_fetch($urandom, 0);

        do_commit(3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3025);
        for (int i = 0; i < 3; i++) begin
            commit     = 1'b1;
            next_pc_op = NPC_SEQ;
            step();
        end
        commit = 1'b0;
        check("halt_sticky_err", fetch_err, 1'b1);
        check("halt_pc_kept", pc, 32'h0000_3024);
        check("halt_no_req", imem_req, 1'b0);

        reset = 1'b0;
        #1 check_reset_state("reset_clears_err");
        step();
        reset = 1'b1;
        m_pc  = 32'h0000_3000;
        step();
        do_fetch(32'h1234_5678, 0);

        do_commit(3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step();
        reset = 1'b0;
        #1 check_reset_state("reset_mid_wait");
        step();
        reset = 1'b1;
        m_pc  = 32'h0000_3000;
        step();

`ifdef IFU_TIMEOUT_EN
        check("to_req", imem_req, 1'b1);
        step();
        for (int i = 1; i < TO; i++) begin
            check("to_no_err_yet", fetch_err, 1'b0);
            step();
        end
        check("to_last_wait_no_err", fetch_err, 1'b0);
        step();
        check("to_err", fetch_err, 1'b1);
        check("to_not_valid", instr_valid, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("to_edge_req", imem_req, 1'b1);
        step();
        for (int i = 1; i < TO; i++) step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0004;
        step();
        imem_rvalid = 1'b0;
        check("to_edge_valid", instr_valid, 1'b1);
        check("to_edge_instr", instr, 32'hCAFE_0004);
        check("to_edge_no_err", fetch_err, 1'b0);
`else
        check("long_wait_req", imem_req, 1'b1);
        step();
        repeat (40) step();
        check("long_wait_no_err", fetch_err, 1'b0);
        check("long_wait_not_valid", instr_valid, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0040;
        step();
        imem_rvalid = 1'b0;
        check("long_wait_valid", instr_valid, 1'b1);
        check("long_wait_instr", instr, 32'hCAFE_0040);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
